systolic_bank_ctrl: RTL and testbench

Sequencer for one systolic bank: a 3x4 PE array with one accumulator (AC) per column and a chained BN-parameter path through the ACs. On a start command it latches the job configuration and, if BN is enabled, streams BN parameters into the AC chain. It then streams input vectors under a valid handshake and drives the row-active and per-column PE control bits. It also generates the per-column skewed accumulate-enable (G) and flush (F) strobes, drains the pipeline, and reports done.

---
 rtl/systolic_ctrl_pkg.sv | 25 ++
 rtl/systolic_bank_ctrl_skew.sv | 26 ++
 rtl/systolic_bank_ctrl.sv | 172 +++++++++++++++++
 tb/tb_systolic_bank_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the systolic bank sequencer:
// FSM state encoding, datapath mode codes and PE control bit positions.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BN_LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam logic MODE_CONV = 1'b0;
    localparam logic MODE_MM   = 1'b1;

    // Each column carries a 6-bit {A,B,C,D,E,H} control slice, A in the MSB
    localparam int PE_CTRL_W = 6;
    localparam int PE_A      = 5;
    localparam int PE_B      = 4;
    localparam int PE_C      = 3;
    localparam int PE_D      = 2;
    localparam int PE_E      = 1;
    localparam int PE_H      = 0;

endpackage

// File: rtl/systolic_bank_ctrl_skew.sv
// Clearable shift register; taps[k] is din delayed by DEPTH-NTAPS+k+1 cycles.
// No backpressure: shifts every cycle, so input bubbles travel as gaps.
module skew_delay #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 6,
    parameter int NTAPS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    output logic [NTAPS-1:0][WIDTH-1:0]  taps
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign taps = sr[DEPTH-1 -: NTAPS];

endmodule

// File: rtl/systolic_bank_ctrl.sv
// Sequencer for one systolic bank: BN load, vector streaming, skewed G/F strobes, drain, done.
// Input side is valid/ready on BN words and vectors; stalls only delay, never drop, transfers.
module systolic_bank_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int NCOLS    = 4,
    parameter int NROWS    = 3,
    parameter int LEN_W    = 10,
    parameter int PE_LAT   = 3,
    parameter int BN_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cfg_conv_mm,
    input  logic                        cfg_isac,
    input  logic                        cfg_isrelu,
    input  logic                        cfg_isbn,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic [NROWS-1:0]            cfg_row_mask,
    input  logic [PE_CTRL_W*NCOLS-1:0]  cfg_pe_ctrl,
    input  logic                        src_valid,
    output logic                        src_ready,
    input  logic                        bn_valid,
    input  logic [15:0]                 bn_data,
    output logic                        bn_ready,
    output logic                        in_en,
    output logic [NROWS-1:0]            active,
    output logic                        conv_mm,
    output logic                        isac,
    output logic                        isrelu,
    output logic                        isbn,
    output logic [PE_CTRL_W*NCOLS-1:0]  pe_ctrl,
    output logic [15:0]                 bn_param_in,
    output logic                        bn_param_in_en,
    output logic [NCOLS-1:0]            g_en,
    output logic [NCOLS-1:0]            f_en,
    output logic                        busy,
    output logic                        done
);

    localparam int SKEW = PE_LAT + NCOLS - 1;
    localparam int DW   = $clog2(SKEW + 1);
    localparam int BW   = $clog2(BN_WORDS + 1);

    state_t                      state, state_nxt;
    logic [LEN_W-1:0]            len_q, len_cnt;
    logic [NROWS-1:0]            row_mask_q;
    logic [BW-1:0]               bn_cnt;
    logic [DW-1:0]               drain_cnt;
    logic                        bn_xfer, src_xfer, last;
    logic [NCOLS-1:0][1:0]       skew_taps;

    assign bn_xfer  = (state == BN_LOAD) && bn_valid;
    assign src_xfer = (state == STREAM) && src_valid;
    assign last     = src_xfer && (len_cnt == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_isbn)
                        state_nxt = BN_LOAD;
                    else if (cfg_len != '0)
                        state_nxt = STREAM;
                    else
                        state_nxt = DONE;
                end
            end
            BN_LOAD: begin
                if (bn_xfer && bn_cnt == BW'(BN_WORDS - 1))
                    state_nxt = (len_q != '0) ? STREAM : DONE;
            end
            STREAM: begin
                if (last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DW'(SKEW - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bn_ready       = 1'b0;
        bn_param_in    = '0;
        bn_param_in_en = 1'b0;
        src_ready      = 1'b0;
        in_en          = 1'b0;
        active         = '0;
        busy           = (state != IDLE);
        done           = (state == DONE);
        case (state)
            BN_LOAD: begin
                bn_ready       = 1'b1;
                bn_param_in    = bn_data;
                bn_param_in_en = bn_valid;
            end
            STREAM: begin
                src_ready = 1'b1;
                in_en     = src_valid;
                active    = row_mask_q;
            end
            DRAIN:   active = row_mask_q;
            default: ;
        endcase
    end

    // Config stays visible after the job so the bank keeps its mode while idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            conv_mm    <= 1'b0;
            isac       <= 1'b0;
            isrelu     <= 1'b0;
            isbn       <= 1'b0;
            pe_ctrl    <= '0;
            len_q      <= '0;
            row_mask_q <= '0;
            bn_cnt     <= '0;
            len_cnt    <= '0;
            drain_cnt  <= '0;
        end else begin
            if (state == IDLE && start) begin
                conv_mm    <= cfg_conv_mm;
                isac       <= cfg_isac;
                isrelu     <= cfg_isrelu;
                isbn       <= cfg_isbn;
                pe_ctrl    <= cfg_pe_ctrl;
                len_q      <= cfg_len;
                row_mask_q <= cfg_row_mask;
                bn_cnt     <= '0;
                len_cnt    <= '0;
            end
            if (bn_xfer)
                bn_cnt <= bn_cnt + 1'b1;
            if (src_xfer)
                len_cnt <= len_cnt + 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    skew_delay #(
        .WIDTH (2),
        .DEPTH (SKEW),
        .NTAPS (NCOLS)
    ) u_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({last, in_en}),
        .taps (skew_taps)
    );

    always_comb begin
        for (int j = 0; j < NCOLS; j++) begin
            g_en[j] = skew_taps[j][0];
            f_en[j] = skew_taps[j][1];
        end
    end

endmodule

// File: tb/tb_systolic_bank_ctrl.sv
// Bench for systolic_bank_ctrl: table of jobs with expected done latency,
// scoreboard queues for skewed G/F strobes and BN words, plus reset/restart sequences.
module tb_systolic_bank_ctrl;
    import systolic_ctrl_pkg::*;

    localparam int NCOLS    = 4;
    localparam int NROWS    = 3;
    localparam int LEN_W    = 10;
    localparam int PE_LAT   = 3;
    localparam int BN_WORDS = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 cfg_conv_mm = 1'b0, cfg_isac = 1'b0, cfg_isrelu = 1'b0, cfg_isbn = 1'b0;
    logic [LEN_W-1:0]     cfg_len = '0;
    logic [NROWS-1:0]     cfg_row_mask = '0;
    logic [6*NCOLS-1:0]   cfg_pe_ctrl = '0;
    logic                 src_valid = 1'b0, src_ready;
    logic                 bn_valid = 1'b0, bn_ready;
    logic [15:0]          bn_data = '0;
    logic                 in_en;
    logic [NROWS-1:0]     active;
    logic                 conv_mm, isac, isrelu, isbn;
    logic [6*NCOLS-1:0]   pe_ctrl;
    logic [15:0]          bn_param_in;
    logic                 bn_param_in_en;
    logic [NCOLS-1:0]     g_en, f_en;
    logic                 busy, done;

    systolic_bank_ctrl #(
        .NCOLS(NCOLS), .NROWS(NROWS), .LEN_W(LEN_W), .PE_LAT(PE_LAT), .BN_WORDS(BN_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_conv_mm(cfg_conv_mm), .cfg_isac(cfg_isac), .cfg_isrelu(cfg_isrelu), .cfg_isbn(cfg_isbn),
        .cfg_len(cfg_len), .cfg_row_mask(cfg_row_mask), .cfg_pe_ctrl(cfg_pe_ctrl),
        .src_valid(src_valid), .src_ready(src_ready),
        .bn_valid(bn_valid), .bn_data(bn_data), .bn_ready(bn_ready),
        .in_en(in_en), .active(active),
        .conv_mm(conv_mm), .isac(isac), .isrelu(isrelu), .isbn(isbn), .pe_ctrl(pe_ctrl),
        .bn_param_in(bn_param_in), .bn_param_in_en(bn_param_in_en),
        .g_en(g_en), .f_en(f_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int   t;
        logic f;
    } sk_t;

    sk_t         gq[NCOLS][$];
    logic [15:0] bnq[$];
    logic        mon_en = 1'b0;

    // Scoreboard: pop strobes expected in this cycle and compare
    always @(negedge clk) begin
        logic [NCOLS-1:0] eg, ef;
        if (mon_en) begin
            eg = '0;
            ef = '0;
            for (int c = 0; c < NCOLS; c++) begin
                if (gq[c].size() > 0 && gq[c][0].t == cyc) begin
                    eg[c] = 1'b1;
                    ef[c] = gq[c][0].f;
                    void'(gq[c].pop_front());
                end
            end
            chk("g_en", 32'(g_en), 32'(eg));
            chk("f_en", 32'(f_en), 32'(ef));
            if (bn_param_in_en) begin
                if (bnq.size() == 0) begin
                    chk("bn_unexpected", 32'(bn_param_in_en), 32'd0);
                end else begin
                    chk("bn_word", 32'(bn_param_in), 32'(bnq[0]));
                    void'(bnq.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic              conv_mm;
        logic              isbn;
        int                len;
        logic [15:0]       pat;
        logic [NROWS-1:0]  rows;
        logic [6*NCOLS-1:0] pe;
        logic              poke;
        int                exp_done;
    } job_t;

    job_t jobs[6];

    task automatic next_cycle();
        @(posedge clk);
        #1;
        start     = 1'b0;
        src_valid = 1'b0;
        bn_valid  = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        int c0, k, t, words, last_cyc, done_cyc, done_cnt;
        next_cycle();
        c0           = cyc;
        start        = 1'b1;
        cfg_conv_mm  = j.conv_mm;
        cfg_isac     = 1'b1;
        cfg_isrelu   = ~j.conv_mm;
        cfg_isbn     = j.isbn;
        cfg_len      = LEN_W'(j.len);
        cfg_row_mask = j.rows;
        cfg_pe_ctrl  = j.pe;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        last_cyc = c0;

        if (j.isbn) begin
            words = 0;
            k = 0;
            while (words < BN_WORDS) begin
                next_cycle();
                bn_valid  = (k % 2 == 0);
                src_valid = 1'b1;
                bn_data   = 16'hB000 + 16'(words * 16'h0111) + 16'(j.len);
                if (bn_valid) begin
                    bnq.push_back(bn_data);
                    words++;
                    last_cyc = cyc;
                end
                @(negedge clk);
                chk("bn_ready", 32'(bn_ready), 32'd1);
                chk("in_en_during_bn", 32'(in_en), 32'd0);
                k++;
            end
        end

        t = 0;
        k = 0;
        while (t < j.len && k < 16) begin
            next_cycle();
            src_valid = j.pat[k];
            if (src_valid) begin
                for (int c = 0; c < NCOLS; c++)
                    gq[c].push_back('{cyc + PE_LAT + c, (t == j.len - 1)});
                t++;
                last_cyc = cyc;
            end
            @(negedge clk);
            chk("in_en", 32'(in_en), 32'(src_valid));
            chk("active", 32'(active), 32'(j.rows));
            chk("src_ready", 32'(src_ready), 32'd1);
            k++;
        end

        done_cyc = -1;
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            next_cycle();
            if (j.poke && n == 1) begin
                start       = 1'b1;
                cfg_conv_mm = ~j.conv_mm;
                cfg_pe_ctrl = ~j.pe;
                cfg_len     = LEN_W'(9);
            end
            @(negedge clk);
            chk("in_en_after_stream", 32'(in_en), 32'd0);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("active_in_done", 32'(active), 32'd0);
            end
            if (done_cyc >= 0 && !done) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                break;
            end
            chk("busy_in_job", 32'(busy), 32'd1);
        end
        chk("done_latency", 32'(done_cyc - c0), 32'(j.exp_done));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        if (j.len > 0)
            chk("done_after_last_in_en", 32'(done_cyc - last_cyc), 32'(PE_LAT + NCOLS));
        chk("conv_mm_latched", 32'(conv_mm), 32'(j.conv_mm));
        chk("pe_ctrl_latched", 32'(pe_ctrl), 32'(j.pe));
        chk("isbn_latched", 32'(isbn), 32'(j.isbn));
        chk("isac_latched", 32'(isac), 32'd1);
        chk("bn_queue_drained", 32'(bnq.size()), 32'd0);
        for (int c = 0; c < NCOLS; c++)
            chk("g_queue_drained", 32'(gq[c].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        conv_mm    isbn len pat       rows    pe            poke exp_done
        jobs[0] = '{MODE_MM,   1'b0, 5, 16'hFFFF, 3'b111, 24'hABCDEF, 1'b0, 12};
        jobs[1] = '{MODE_CONV, 1'b1, 2, 16'hFFFF, 3'b011, 24'h123456, 1'b0, 24};
        jobs[2] = '{MODE_MM,   1'b0, 3, 16'h0019, 3'b110, 24'h0F0F0F, 1'b0, 12};
        jobs[3] = '{MODE_CONV, 1'b0, 0, 16'h0000, 3'b111, 24'h555555, 1'b0, 1};
        jobs[4] = '{MODE_MM,   1'b1, 0, 16'h0000, 3'b001, 24'h333333, 1'b0, 16};
        jobs[5] = '{MODE_CONV, 1'b0, 4, 16'hFFFF, 3'b010, 24'hC3C3C3, 1'b1, 11};

        rst = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_en", 32'(in_en), 32'd0);
        chk("rst_g_en", 32'(g_en), 32'd0);
        chk("rst_pe_ctrl", 32'(pe_ctrl), 32'd0);
        chk("rst_ready", 32'({src_ready, bn_ready}), 32'd0);
        next_cycle();
        rst = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++)
            run_job(jobs[i]);

        // Reset while the third vector is being transferred
        mon_en = 1'b0;
        next_cycle();
        start        = 1'b1;
        cfg_conv_mm  = MODE_MM;
        cfg_isbn     = 1'b0;
        cfg_len      = LEN_W'(5);
        cfg_row_mask = 3'b111;
        cfg_pe_ctrl  = 24'h777777;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            src_valid = 1'b1;
            if (k == 3) rst = 1'b0;
        end
        next_cycle();
        rst = 1'b1;
        src_valid = 1'b1;
        @(negedge clk);
        chk("abort_in_en", 32'(in_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_active", 32'(active), 32'd0);
        chk("abort_g_en", 32'(g_en), 32'd0);
        chk("abort_f_en", 32'(f_en), 32'd0);
        chk("abort_cfg", 32'({conv_mm, isac, pe_ctrl}), 32'd0);
        for (int c = 0; c < NCOLS; c++) gq[c].delete();
        bnq.delete();
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        mon_en = 1'b1;
        run_job(jobs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
